// File: rtl/cdot_pkg.sv
// Shared definitions for the complex dot-product engine: default geometry, accumulator sizing,
// result narrowing helpers and accumulator FSM encoding.
package cdot_pkg;

    localparam int unsigned CDOT_LANES     = 4;
    localparam int unsigned CDOT_WIDTH     = 16;
    localparam int unsigned CDOT_FRAC      = 8;
    localparam int unsigned CDOT_BEATS_MAX = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cdot_state_e;

    // Lossless accumulator width: lane product + lane growth + beat growth.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned lanes,
                                          input int unsigned beats);
        return width + 1 + $clog2(lanes) + $clog2(beats);
    endfunction

    function automatic longint sat_narrow(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic sat_clip(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        return (v > hi) || (v < lo);
    endfunction

    function automatic longint wrap_narrow(input longint v, input int unsigned w);
        return v & ((longint'(1) <<< w) - 1);
    endfunction

endpackage

// File: rtl/cdot_lane_mult.sv
// One complex multiplier lane: full-precision product, floor shift by FRAC, registered at WIDTH+1 bits.
module cdot_lane_mult #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_r,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_r,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   p_r,
    output logic [WIDTH:0]   p_i
);

    localparam int unsigned PW = 2 * WIDTH + 1;

    logic signed [PW-1:0] ar;
    logic signed [PW-1:0] ai;
    logic signed [PW-1:0] br;
    logic signed [PW-1:0] bi;
    logic signed [PW-1:0] re_full;
    logic signed [PW-1:0] im_full;

    assign ar = PW'($signed(a_r));
    assign ai = PW'($signed(a_i));
    assign br = PW'($signed(b_r));
    assign bi = PW'($signed(b_i));

    assign re_full = (ar * br) - (ai * bi);
    assign im_full = (ar * bi) + (ai * br);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0;
            p_i <= '0;
        end else if (en) begin
            p_r <= (WIDTH + 1)'(re_full >>> FRAC);
            p_i <= (WIDTH + 1)'(im_full >>> FRAC);
        end
    end

endmodule

// File: rtl/cplx_dot_engine.sv
// Streaming complex inner product: lane multiply, adder tree, beat accumulator, output register.
// Optional CDOT_SAT_EN saturates the narrowed result instead of wrapping.
module cplx_dot_engine
    import cdot_pkg::*;
#(
    parameter int unsigned LANES     = CDOT_LANES,
    parameter int unsigned WIDTH     = CDOT_WIDTH,
    parameter int unsigned FRAC      = CDOT_FRAC,
    parameter int unsigned BEATS_MAX = CDOT_BEATS_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*WIDTH-1:0] in_a_r,
    input  logic [LANES*WIDTH-1:0] in_a_i,
    input  logic [LANES*WIDTH-1:0] in_b_r,
    input  logic [LANES*WIDTH-1:0] in_b_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_r,
    output logic [WIDTH-1:0]       out_i,
    output logic                   out_sat,
    output logic                   out_ovf
);

    localparam int unsigned ACC_W = acc_w(WIDTH, LANES, BEATS_MAX);
    localparam int unsigned CNT_W = $clog2(BEATS_MAX + 1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [WIDTH:0] lane_r [LANES];
    logic [WIDTH:0] lane_i [LANES];

    // Lane 0 occupies the most significant slice of each operand bus.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cdot_lane_mult #(
            .WIDTH(WIDTH),
            .FRAC (FRAC)
        ) u_lane (
            .clk(clk),
            .rst(rst),
            .en (advance),
            .a_r(in_a_r[(LANES-1-l)*WIDTH +: WIDTH]),
            .a_i(in_a_i[(LANES-1-l)*WIDTH +: WIDTH]),
            .b_r(in_b_r[(LANES-1-l)*WIDTH +: WIDTH]),
            .b_i(in_b_i[(LANES-1-l)*WIDTH +: WIDTH]),
            .p_r(lane_r[l]),
            .p_i(lane_i[l])
        );
    end

    logic s1_valid;
    logic s1_last;
    logic s2_valid;
    logic s2_last;
    logic signed [ACC_W-1:0] tree_r;
    logic signed [ACC_W-1:0] tree_i;
    logic signed [ACC_W-1:0] s2_r;
    logic signed [ACC_W-1:0] s2_i;

    // Adder tree over lanes, sign-extended to the accumulator width.
    always_comb begin
        tree_r = '0;
        tree_i = '0;
        for (int l = 0; l < LANES; l++) begin
            tree_r = tree_r + ACC_W'($signed(lane_r[l]));
            tree_i = tree_i + ACC_W'($signed(lane_i[l]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_r     <= '0;
            s2_i     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && in_last;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_r     <= tree_r;
            s2_i     <= tree_i;
        end
    end

    cdot_state_e state_q;
    cdot_state_e state_d;
    logic [CNT_W-1:0] cnt_q;
    logic signed [ACC_W-1:0] acc_r_q;
    logic signed [ACC_W-1:0] acc_i_q;
    logic signed [ACC_W-1:0] sum_r;
    logic signed [ACC_W-1:0] sum_i;
    logic hit_max;
    logic close_c;
    logic ovf_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (advance) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (s2_valid) begin
            state_d = close_c ? ST_IDLE : ST_RUN;
        end
    end

    // Close on an explicit last, or force-close once the beat budget is used up.
    always_comb begin
        sum_r   = s2_r;
        sum_i   = s2_i;
        hit_max = 1'b0;
        close_c = 1'b0;
        ovf_c   = 1'b0;
        if (state_q == ST_RUN) begin
            sum_r = acc_r_q + s2_r;
            sum_i = acc_i_q + s2_i;
        end
        hit_max = (cnt_q == CNT_W'(BEATS_MAX - 1));
        close_c = s2_valid && (s2_last || hit_max);
        ovf_c   = s2_valid && hit_max && !s2_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r_q   <= '0;
            acc_i_q   <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (advance) begin
            if (s2_valid) begin
                if (close_c) begin
                    acc_r_q <= '0;
                    acc_i_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    acc_r_q <= sum_r;
                    acc_i_q <= sum_i;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
            end
            out_valid <= close_c;
            if (close_c) begin
`ifdef CDOT_SAT_EN
                out_r   <= WIDTH'(sat_narrow(longint'(sum_r), WIDTH));
                out_i   <= WIDTH'(sat_narrow(longint'(sum_i), WIDTH));
                out_sat <= sat_clip(longint'(sum_r), WIDTH) || sat_clip(longint'(sum_i), WIDTH);
`else
                out_r   <= WIDTH'(wrap_narrow(longint'(sum_r), WIDTH));
                out_i   <= WIDTH'(wrap_narrow(longint'(sum_i), WIDTH));
                out_sat <= 1'b0;
`endif
                out_ovf <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_cplx_dot_engine.sv
// Self-checking bench for cplx_dot_engine: directed cases plus randomized vectors against a
// behavioural inner-product model (honours CDOT_SAT_EN when defined).
module tb_cplx_dot_engine;

    localparam int LANES = 4;
    localparam int W     = 16;
    localparam int BMAX  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [LANES*W-1:0] in_a_r;
    logic [LANES*W-1:0] in_a_i;
    logic [LANES*W-1:0] in_b_r;
    logic [LANES*W-1:0] in_b_i;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_r;
    logic [W-1:0]       out_i;
    logic               out_sat;
    logic               out_ovf;

    cplx_dot_engine dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .in_a_r   (in_a_r),
        .in_a_i   (in_a_i),
        .in_b_r   (in_b_r),
        .in_b_i   (in_b_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_i    (out_i),
        .out_sat  (out_sat),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint r;
        longint i;
        bit     sat;
        bit     ovf;
    } res_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    res_t   exp_q[$];
    longint m_acc_r, m_acc_i;
    int     m_cnt;
    int     n_out;
    longint last_r, last_i;
    bit     last_sat, last_ovf;
    bit     rand_rdy;
    longint a_r[LANES], a_i[LANES], b_r[LANES], b_i[LANES];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic longint trunc17(input longint v);
        longint t;
        t = v & 64'h1FFFF;
        if (t >= 65536) t = t - 131072;
        return t;
    endfunction

    function automatic longint narrow16(input longint v, output bit s);
`ifdef CDOT_SAT_EN
        s = 1'b0;
        if (v > 32767) begin s = 1'b1; return 64'h7FFF; end
        if (v < -32768) begin s = 1'b1; return 64'h8000; end
        return v & 64'hFFFF;
`else
        s = 1'b0;
        return v & 64'hFFFF;
`endif
    endfunction

    // Reference: exact complex products, floor-scaled, kept at 17 bits, summed over lanes and beats.
    task automatic model_beat(input bit last);
        longint sr, si;
        bit     s1, s2;
        res_t   e;
        sr = 0;
        si = 0;
        for (int l = 0; l < LANES; l++) begin
            sr += trunc17((a_r[l] * b_r[l] - a_i[l] * b_i[l]) >>> 8);
            si += trunc17((a_r[l] * b_i[l] + a_i[l] * b_r[l]) >>> 8);
        end
        m_acc_r += sr;
        m_acc_i += si;
        m_cnt++;
        if (last || m_cnt == BMAX) begin
            e.r   = narrow16(m_acc_r, s1);
            e.i   = narrow16(m_acc_i, s2);
            e.sat = s1 | s2;
            e.ovf = !last;
            exp_q.push_back(e);
            m_acc_r = 0;
            m_acc_i = 0;
            m_cnt   = 0;
        end
    endtask

    always @(negedge clk) begin
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_r", out_r, e.r);
                check("out_i", out_i, e.i);
                check("out_sat", out_sat, e.sat);
                check("out_ovf", out_ovf, e.ovf);
            end
            n_out++;
            last_r   = out_r;
            last_i   = out_i;
            last_sat = out_sat;
            last_ovf = out_ovf;
        end
    end

    task automatic drive_bus();
        for (int l = 0; l < LANES; l++) begin
            in_a_r[(LANES-1-l)*W +: W] = 16'(a_r[l]);
            in_a_i[(LANES-1-l)*W +: W] = 16'(a_i[l]);
            in_b_r[(LANES-1-l)*W +: W] = 16'(b_r[l]);
            in_b_i[(LANES-1-l)*W +: W] = 16'(b_i[l]);
        end
    endtask

    task automatic set_uniform(input longint ar, input longint ai, input longint br, input longint bi);
        for (int l = 0; l < LANES; l++) begin
            a_r[l] = ar; a_i[l] = ai; b_r[l] = br; b_i[l] = bi;
        end
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < LANES; l++) begin
            a_r[l] = longint'($signed(16'($urandom())));
            a_i[l] = longint'($signed(16'($urandom())));
            b_r[l] = longint'($signed(16'($urandom())));
            b_i[l] = longint'($signed(16'($urandom())));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present one beat and hold it until a handshake edge; returns 1 ns after that edge.
    task automatic send_beat(input bit last);
        bit rdy;
        int waits;
        rdy   = 1'b0;
        waits = 0;
        drive_bus();
        in_last  = last;
        in_valid = 1'b1;
        while (!rdy) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            waits++;
            if (!rdy && waits > 200) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
        end
        if (rdy) model_beat(last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int waits;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        waits = 0;
        while ((exp_q.size() != 0 || out_valid) && waits < 100) begin
            tick();
            waits++;
        end
        if (waits >= 100) check("drain_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int len;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_a_r = '0; in_a_i = '0; in_b_r = '0; in_b_i = '0;
        out_ready = 1'b1;
        rand_rdy = 1'b0;
        m_acc_r = 0; m_acc_i = 0; m_cnt = 0; n_out = 0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single beat and latency
        set_uniform(64'h0100, 64'h0100, 64'h0080, 0);
        send_beat(1'b1);
        check("t1_lat1", out_valid, 0);
        tick();
        check("t1_lat2", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_r", out_r, 16'h0200);
        check("t1_i", out_i, 16'h0200);
        check("t1_ovf", out_ovf, 0);
        drain();

        // three-beat vector
        n0 = n_out;
        send_beat(1'b0);
        check("t2_nov1", out_valid, 0);
        send_beat(1'b0);
        check("t2_nov2", out_valid, 0);
        send_beat(1'b1);
        check("t2_nov3", out_valid, 0);
        drain();
        check("t2_count", n_out - n0, 1);
        check("t2_r", last_r, 16'h0600);
        check("t2_i", last_i, 16'h0600);

        // narrowing of an out-of-range sum
        set_uniform(64'h7F00, 0, 64'h0200, 0);
        send_beat(1'b1);
        drain();
`ifdef CDOT_SAT_EN
        check("t3_r", last_r, 16'h7FFF);
        check("t3_sat", last_sat, 1);
`else
        check("t3_r", last_r, 16'hF800);
        check("t3_sat", last_sat, 0);
`endif
        check("t3_i", last_i, 0);

        // backpressure with beats in flight
        n0 = n_out;
        out_ready = 1'b0;
        set_uniform(64'h0100, 64'h0100, 64'h0080, 0);
        send_beat(1'b1);
        rand_lanes();
        send_beat(1'b0);
        send_beat(1'b1);
        rand_lanes();
        drive_bus();
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_in_ready", in_ready, 0);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_r", out_r, 16'h0200);
            check("t4_hold_i", out_i, 16'h0200);
            tick();
        end
        out_ready = 1'b1;
        send_beat(1'b1);
        drain();
        check("t4_count", n_out - n0, 3);

        // asynchronous reset mid-vector
        set_uniform(64'h0100, 64'h0100, 64'h0080, 0);
        send_beat(1'b0);
        send_beat(1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_r", out_r, 0);
        check("t5_i", out_i, 0);
        check("t5_in_ready", in_ready, 1);
        m_acc_r = 0; m_acc_i = 0; m_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        n0 = n_out;
        send_beat(1'b1);
        drain();
        check("t5_count", n_out - n0, 1);
        check("t5_r_after", last_r, 16'h0200);
        check("t5_i_after", last_i, 16'h0200);

        // force-close at the beat limit
        for (int k = 0; k < BMAX; k++) send_beat(1'b0);
        drain();
        check("t6_r", last_r, 16'h0800);
        check("t6_i", last_i, 16'h0800);
        check("t6_ovf", last_ovf, 1);
        send_beat(1'b1);
        drain();
        check("t6_next_ovf", last_ovf, 0);

        // randomized vectors with random backpressure
        rand_rdy = 1'b1;
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 5);
            for (int j = 0; j < len; j++) begin
                rand_lanes();
                send_beat(j == len - 1);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        drain();
        check("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
